// File: rtl/tinker_pkg.sv
// tinker_pkg: shared constants and fetch-queue entry type for the Tinker front end
package tinker_pkg;
  localparam int TINKER_ADDR_W = 64;
  localparam int TINKER_INSTR_W = 32;
  localparam logic [63:0] TINKER_RESET_PC = 64'h2000;
  localparam int TINKER_PC_STEP = 4;
  typedef struct packed {
    logic [TINKER_ADDR_W-1:0] pc;
    logic [TINKER_INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/tinker_sync_fifo.sv
// tinker_sync_fifo: power-of-2 circular queue with registered storage; flush beats push/pop
module tinker_sync_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_q + PW'(do_pop);
      wr_q <= wr_q + PW'(do_push);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/tinker_prefetch_unit.sv
// tinker_prefetch_unit: credit-limited pipelined instruction fetch with a PC-tagged queue
// and redirect-time discard of stale in-flight responses.
module tinker_prefetch_unit import tinker_pkg::*; #(
  parameter int ADDR_W = TINKER_ADDR_W,
  parameter int INSTR_W = TINKER_INSTR_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(TINKER_RESET_PC),
  parameter int PC_STEP = TINKER_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, occ;
  logic halt_q, req_fire, push, pop, full, empty;
  logic [ADDR_W+INSTR_W-1:0] head;
  // Queue slots are reserved at issue time, so an accepted response always fits.
  assign mem_req_valid = !reset && !halt_q && !redirect &&
                         ({1'b0, occ} + {1'b0, inflight_q} < (CW+1)'(DEPTH));
  assign mem_req_addr = fetch_pc_q;
  assign req_fire = mem_req_valid && mem_req_ready;
  assign push = mem_rsp_valid && drop_q == '0 && !redirect && !full;
  assign pop = inst_valid && inst_ready;
  assign inst_valid = !empty;
  assign {inst_pc, inst_data} = head;
  assign halted = halt_q && inflight_q == '0;
  always_comb begin
    inflight_d = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid);
    drop_d = redirect ? inflight_q - CW'(mem_rsp_valid) : drop_q - CW'(mem_rsp_valid && drop_q != '0);
    fetch_pc_d = redirect ? redirect_pc : req_fire ? fetch_pc_q + STEP : fetch_pc_q;
    rsp_pc_d = redirect ? redirect_pc : push ? rsp_pc_q + STEP : rsp_pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q <= '0;
      halt_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
      halt_q <= halt_q || halt;
    end
  end
  tinker_sync_fifo #(.W(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din({rsp_pc_q, mem_rsp_data}),
    .dout(head),
    .count(occ),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_tinker_prefetch_unit.sv
// tb_tinker_prefetch_unit: random memory/decoder/redirect traffic against an epoch-tagged
// reference model; a separate monitor scores every instruction the decoder consumes.
module tb_tinker_prefetch_unit;
  localparam int DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h2000;
  typedef struct { logic [63:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] data; } exp_t;
  logic clk = 0, reset = 1;
  logic mem_req_valid, mem_req_ready = 0, mem_rsp_valid = 0;
  logic [63:0] mem_req_addr, inst_pc, redirect_pc = 0;
  logic [31:0] mem_rsp_data = 0, inst_data;
  logic inst_valid, inst_ready = 0, redirect = 0, halt = 0, halted;
  int checks = 0, errors = 0;
  mreq_t mq[$];
  exp_t exp_q[$];
  exp_t mon_e;
  logic [63:0] pc_m = RESET_PC;
  int occ_m = 0, epoch = 0, cyc = 0;
  bit halt_m = 0, halt_req = 0, force_redir = 0, rsp_now;
  logic [63:0] force_pc;
  int rdy_pct = 100, irdy_pct = 100, redir_pct = 0, lat_lo = 1, lat_hi = 1;

  tinker_prefetch_unit dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdat(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h data %h expected nothing", inst_pc, inst_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("inst_pc", inst_pc, mon_e.pc);
        chk("inst_data", {32'b0, inst_data}, {32'b0, mon_e.data});
      end
    end
  end

  task automatic step();
    mreq_t r;
    bit exp_v, fire;
    @(posedge clk); #1;
    cyc++;
    mem_req_ready = $urandom_range(99) < rdy_pct;
    inst_ready = $urandom_range(99) < irdy_pct;
    redirect = force_redir || ($urandom_range(99) < redir_pct);
    redirect_pc = force_redir ? force_pc : ({$urandom, $urandom} & ~64'h3);
    force_redir = 0;
    halt = halt_req;
    rsp_now = mq.size() != 0 && mq[0].due <= cyc;
    mem_rsp_valid = rsp_now;
    mem_rsp_data = rsp_now ? fdat(mq[0].addr) : $urandom;
    @(negedge clk); #1;
    exp_v = !halt_m && !redirect && (occ_m + mq.size() < DEPTH);
    chk("req_valid", {63'b0, mem_req_valid}, {63'b0, exp_v});
    if (exp_v) chk("req_addr", mem_req_addr, pc_m);
    chk("inst_valid", {63'b0, inst_valid}, {63'b0, occ_m > 0});
    chk("halted", {63'b0, halted}, {63'b0, halt_m && mq.size() == 0});
    fire = mem_req_valid && mem_req_ready;
    if (rsp_now) r = mq.pop_front();
    if (redirect) begin
      occ_m = 0;
      epoch++;
      exp_q.delete();
      pc_m = redirect_pc;
    end else begin
      if (rsp_now && r.epoch == epoch) occ_m++;
      if (inst_valid && inst_ready) occ_m--;
    end
    if (fire) begin
      mq.push_back('{addr: mem_req_addr, epoch: epoch, due: cyc + $urandom_range(lat_hi, lat_lo)});
      exp_q.push_back('{pc: pc_m, data: fdat(pc_m)});
      pc_m += 64'd4;
    end
    if (halt) halt_m = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    mem_req_ready = 0; mem_rsp_valid = 0; inst_ready = 0; redirect = 0; halt = 0;
    #1;
    chk("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
    chk("rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
    chk("rst_halted", {63'b0, halted}, 64'd0);
    mq.delete(); exp_q.delete();
    occ_m = 0; halt_m = 0; halt_req = 0; pc_m = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic redir_to(input logic [63:0] pc);
    force_redir = 1;
    force_pc = pc;
    step();
  endtask

  initial begin
    do_reset();
    repeat (20) step();
    irdy_pct = 0;
    repeat (10) step();
    irdy_pct = 100;
    repeat (10) step();
    lat_lo = 3; lat_hi = 3;
    repeat (6) step();
    redir_to(64'h3000);
    repeat (15) step();
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    redir_to(64'h3000);
    repeat (6) step();
    redir_to(64'hFFFF_FFFF_FFFF_FFF8);
    repeat (10) step();
    rdy_pct = 70; irdy_pct = 60; lat_lo = 1; lat_hi = 4; redir_pct = 8;
    repeat (600) step();
    redir_pct = 0; rdy_pct = 100; irdy_pct = 100; lat_lo = 2; lat_hi = 2;
    repeat (6) step();
    halt_req = 1;
    repeat (20) step();
    redir_to(64'h4000);
    repeat (8) step();
    do_reset();
    lat_lo = 1; lat_hi = 1; irdy_pct = 0;
    repeat (3) step();
    do_reset();
    rdy_pct = 80; irdy_pct = 70; lat_lo = 1; lat_hi = 3; redir_pct = 5;
    repeat (300) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
